// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RAM access modes and default memory geometry.
package cpu_pkg;

    typedef enum logic [1:0] {
        RAM_RANDOM = 2'b00,
        RAM_STREAM = 2'b01,
        RAM_STACK  = 2'b10
    } ram_mode_t;

    localparam int unsigned RAM_DATA_W = 8;
    localparam int unsigned RAM_DEPTH  = 32;

endpackage

// File: rtl/ram_stream_unit_if.sv
// CPU-side bus of ram_stream_unit: control, strobes, data and status flags.
// RAM_MONITOR_EN adds the debug monitor signals.
interface ram_stream_unit_if
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned DEPTH  = RAM_DEPTH
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              clr;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] addr;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              err;
`ifdef RAM_MONITOR_EN
    logic [ADDR_W-1:0] mon_wptr;
    logic [ADDR_W-1:0] mon_rptr;
    logic [DATA_W-1:0] mon_last_wr;
`endif

    modport master (
        output clr, mode, addr, wr_en, rd_en, din,
        input  dout, rd_valid, full, empty, count, err
`ifdef RAM_MONITOR_EN
        , input mon_wptr, mon_rptr, mon_last_wr
`endif
    );

    modport slave (
        input  clr, mode, addr, wr_en, rd_en, din,
        output dout, rd_valid, full, empty, count, err
`ifdef RAM_MONITOR_EN
        , output mon_wptr, mon_rptr, mon_last_wr
`endif
    );

endinterface

// File: rtl/ram_core.sv
// Synchronous word array: one write port, one registered read port, read-before-write.
module ram_core
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned DEPTH  = RAM_DEPTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic              rd_zero,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Array itself is never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rd_zero forces a zero word for reads that fall outside the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_zero ? '0 : mem[raddr];
        end
    end

endmodule

// File: rtl/ram_stream_unit.sv
// Parametrised CPU data memory with random, stream (FIFO) and stack access modes.
// Define RAM_MONITOR_EN to add the mon_wptr/mon_rptr/mon_last_wr debug outputs.
module ram_stream_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned DEPTH  = RAM_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    ram_stream_unit_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, empty_q, err_q, err_d, rd_valid_q;

    logic              mem_we, mem_re, mem_rd_zero;
    logic [ADDR_W-1:0] mem_waddr, mem_raddr, top_c;
    logic              wr_ok, rd_ok, err_set, in_range;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Address range check is only needed when DEPTH leaves unused address codes.
    if (DEPTH == (1 << ADDR_W)) begin : g_pow2
        assign in_range = 1'b1;
    end else begin : g_npow2
        assign in_range = ({1'b0, bus.addr} < CNT_FULL);
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_rd_zero = 1'b0;
        mem_waddr   = bus.addr;
        mem_raddr   = bus.addr;
        top_c       = ADDR_W'(count_q - 1'b1);
        rd_ok       = bus.rd_en & ~empty_q;
        wr_ok       = bus.wr_en & (~full_q | rd_ok);
        err_set     = (bus.wr_en & ~wr_ok) | (bus.rd_en & ~rd_ok);

        case (mode_q)
            RAM_STREAM: begin
                mem_we    = wr_ok;
                mem_re    = rd_ok;
                mem_waddr = wptr_q;
                mem_raddr = rptr_q;
                if (wr_ok) wptr_d = next_ptr(wptr_q);
                if (rd_ok) rptr_d = next_ptr(rptr_q);
                count_d   = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
            end
            RAM_STACK: begin
                // Push with a concurrent pop replaces the top entry in place.
                mem_we    = wr_ok;
                mem_re    = rd_ok;
                mem_raddr = top_c;
                mem_waddr = rd_ok ? top_c : ADDR_W'(count_q);
                count_d   = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
            end
            default: begin
                mem_we      = bus.wr_en & in_range;
                mem_re      = bus.rd_en;
                mem_rd_zero = ~in_range;
                err_set     = (bus.wr_en | bus.rd_en) & ~in_range;
                count_d     = '0;
            end
        endcase

        err_d = err_q | err_set;

        if (rst || bus.clr) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            mode_q     <= bus.mode;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            full_q     <= (count_d == CNT_FULL);
            empty_q    <= (count_d == '0);
            err_q      <= err_d;
            rd_valid_q <= mem_re;
        end
    end

    ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (bus.din),
        .re      (mem_re),
        .rd_zero (mem_rd_zero),
        .raddr   (mem_raddr),
        .rdata   (bus.dout)
    );

    assign bus.rd_valid = rd_valid_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.err      = err_q;

`ifdef RAM_MONITOR_EN
    logic [DATA_W-1:0] last_wr_q;

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            last_wr_q <= '0;
        end else if (mem_we) begin
            last_wr_q <= bus.din;
        end
    end

    assign bus.mon_wptr    = wptr_q;
    assign bus.mon_rptr    = rptr_q;
    assign bus.mon_last_wr = last_wr_q;
`endif

endmodule

// File: tb/tb_ram_stream_unit.sv
// Scoreboard bench for ram_stream_unit: a DEPTH=32 instance for stream/stack, a DEPTH=24 one for random.
module tb_ram_stream_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] ea, eb;

    always #5 clk = ~clk;

    ram_stream_unit_if #(.DATA_W(8), .DEPTH(32)) a_if ();
    ram_stream_unit_if #(.DATA_W(8), .DEPTH(24)) b_if ();

    ram_stream_unit #(.DATA_W(8), .DEPTH(32)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
    ram_stream_unit #(.DATA_W(8), .DEPTH(24)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitors: every rd_valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (a_if.rd_valid === 1'b1) begin
            if (qa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL a_unexpected_read: got dout %0h expected no rd_valid at %0t", a_if.dout, $time);
            end else begin
                ea = qa.pop_front();
                chk("a_dout", 32'(a_if.dout), 32'(ea));
            end
        end
    end

    always @(negedge clk) begin
        if (b_if.rd_valid === 1'b1) begin
            if (qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL b_unexpected_read: got dout %0h expected no rd_valid at %0t", b_if.dout, $time);
            end else begin
                eb = qb.pop_front();
                chk("b_dout", 32'(b_if.dout), 32'(eb));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_cyc(input logic w, input logic r, input logic [7:0] d);
        a_if.wr_en = w; a_if.rd_en = r; a_if.din = d;
        tick();
        a_if.wr_en = 1'b0; a_if.rd_en = 1'b0;
    endtask

    task automatic a_rd(input logic [7:0] exp);
        qa.push_back(exp);
        a_cyc(1'b0, 1'b1, 8'h00);
    endtask

    task automatic a_both(input logic [7:0] d, input logic [7:0] exp);
        qa.push_back(exp);
        a_cyc(1'b1, 1'b1, d);
    endtask

    // Mode is driven to 11 afterwards to show it is latched only during clr.
    task automatic a_clr(input logic [1:0] m);
        a_if.mode = m; a_if.clr = 1'b1;
        tick();
        a_if.clr = 1'b0; a_if.mode = 2'b11;
    endtask

    task automatic b_cyc(input logic w, input logic r, input logic [4:0] ad, input logic [7:0] d);
        b_if.wr_en = w; b_if.rd_en = r; b_if.addr = ad; b_if.din = d;
        tick();
        b_if.wr_en = 1'b0; b_if.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        a_if.clr = 1'b0; a_if.mode = 2'b01; a_if.addr = '0;
        a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.din = '0;
        b_if.clr = 1'b0; b_if.mode = 2'b00; b_if.addr = '0;
        b_if.wr_en = 1'b0; b_if.rd_en = 1'b0; b_if.din = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_count", 32'(a_if.count), 32'd0);
        chk("rst_empty", 32'(a_if.empty), 32'd1);
        chk("rst_full", 32'(a_if.full), 32'd0);
        chk("rst_err", 32'(a_if.err), 32'd0);
        chk("rst_dout", 32'(a_if.dout), 32'd0);
        chk("rst_rd_valid", 32'(a_if.rd_valid), 32'd0);

        // Random mode on the DEPTH=24 instance
        b_cyc(1'b1, 1'b0, 5'd3, 8'hAA);
        qb.push_back(8'hAA); b_cyc(1'b0, 1'b1, 5'd3, 8'h00);
        qb.push_back(8'hAA); b_cyc(1'b1, 1'b1, 5'd3, 8'h55);
        qb.push_back(8'h55); b_cyc(1'b0, 1'b1, 5'd3, 8'h00);
        b_cyc(1'b1, 1'b0, 5'd23, 8'h3C);
        qb.push_back(8'h3C); b_cyc(1'b0, 1'b1, 5'd23, 8'h00);
        chk("rnd_err_inrange", 32'(b_if.err), 32'd0);
        chk("rnd_count", 32'(b_if.count), 32'd0);
        b_cyc(1'b1, 1'b0, 5'd30, 8'h11);
        chk("rnd_err_oor_wr", 32'(b_if.err), 32'd1);
        qb.push_back(8'h00); b_cyc(1'b0, 1'b1, 5'd30, 8'h00);
        qb.push_back(8'h3C); b_cyc(1'b0, 1'b1, 5'd23, 8'h00);
        chk("rnd_err_sticky", 32'(b_if.err), 32'd1);

        // Stream echo
        a_clr(2'b01);
        for (int i = 1; i <= 32; i++) a_cyc(1'b1, 1'b0, 8'(i));
        chk("echo_full", 32'(a_if.full), 32'd1);
        chk("echo_count", 32'(a_if.count), 32'd32);
        for (int i = 1; i <= 32; i++) a_rd(8'(i));
        tick();
        chk("echo_empty", 32'(a_if.empty), 32'd1);
        chk("echo_err", 32'(a_if.err), 32'd0);

        // Stream wrap
        for (int i = 0; i < 20; i++) a_cyc(1'b1, 1'b0, 8'(100 + i));
        for (int i = 0; i < 20; i++) a_rd(8'(100 + i));
        for (int i = 0; i < 20; i++) a_cyc(1'b1, 1'b0, 8'(200 + i));
        chk("wrap_count", 32'(a_if.count), 32'd20);
        for (int i = 0; i < 20; i++) a_rd(8'(200 + i));
        chk("wrap_empty", 32'(a_if.empty), 32'd1);
        chk("wrap_err", 32'(a_if.err), 32'd0);

        // Stream read+write while full, then while empty
        a_clr(2'b01);
        for (int i = 0; i < 32; i++) a_cyc(1'b1, 1'b0, 8'(10 + i));
        a_both(8'h99, 8'd10);
        chk("fifo_full_both_count", 32'(a_if.count), 32'd32);
        chk("fifo_full_both_err", 32'(a_if.err), 32'd0);
        for (int i = 1; i < 32; i++) a_rd(8'(10 + i));
        a_rd(8'h99);
        chk("fifo_drain_empty", 32'(a_if.empty), 32'd1);
        a_cyc(1'b1, 1'b1, 8'h77);
        chk("fifo_empty_both_err", 32'(a_if.err), 32'd1);
        chk("fifo_empty_both_count", 32'(a_if.count), 32'd1);
        a_rd(8'h77);

        // Stack basics
        a_clr(2'b10);
        chk("clr_err", 32'(a_if.err), 32'd0);
        a_cyc(1'b1, 1'b0, 8'd5);
        a_cyc(1'b1, 1'b0, 8'd6);
        a_cyc(1'b1, 1'b0, 8'd7);
        a_rd(8'd7);
        a_rd(8'd6);
        chk("stk_count1", 32'(a_if.count), 32'd1);
        a_both(8'd9, 8'd5);
        chk("stk_both_count", 32'(a_if.count), 32'd1);
        a_rd(8'd9);
        chk("stk_count0", 32'(a_if.count), 32'd0);
        chk("stk_err", 32'(a_if.err), 32'd0);

        // Stack overflow / underflow
        a_clr(2'b10);
        for (int i = 1; i <= 33; i++) a_cyc(1'b1, 1'b0, 8'(i));
        chk("stk_ovf_count", 32'(a_if.count), 32'd32);
        chk("stk_ovf_full", 32'(a_if.full), 32'd1);
        chk("stk_ovf_err", 32'(a_if.err), 32'd1);
        for (int i = 32; i >= 1; i--) a_rd(8'(i));
        chk("stk_drain_empty", 32'(a_if.empty), 32'd1);
        a_cyc(1'b0, 1'b1, 8'h00);
        tick();
        chk("stk_unf_err", 32'(a_if.err), 32'd1);
        a_clr(2'b10);
        chk("stk_clr_err", 32'(a_if.err), 32'd0);
        a_cyc(1'b1, 1'b1, 8'h44);
        chk("stk_empty_both_err", 32'(a_if.err), 32'd1);
        chk("stk_empty_both_count", 32'(a_if.count), 32'd1);
        a_rd(8'h44);

        // Reset mid-stream, mode re-sampled as stack
        a_clr(2'b01);
        for (int i = 0; i < 10; i++) a_cyc(1'b1, 1'b0, 8'(50 + i));
        a_rd(8'd50);
        chk("mid_count", 32'(a_if.count), 32'd9);
        a_if.mode = 2'b10; rst = 1'b1;
        tick();
        rst = 1'b0; a_if.mode = 2'b11;
        chk("mid_rst_count", 32'(a_if.count), 32'd0);
        chk("mid_rst_empty", 32'(a_if.empty), 32'd1);
        chk("mid_rst_dout", 32'(a_if.dout), 32'd0);
        chk("mid_rst_err", 32'(a_if.err), 32'd0);
        a_cyc(1'b0, 1'b1, 8'h00);
        tick();
        chk("mid_rej_err", 32'(a_if.err), 32'd1);
        a_cyc(1'b1, 1'b0, 8'd3);
        a_cyc(1'b1, 1'b0, 8'd4);
        a_rd(8'd4);
        chk("mid_stack_count", 32'(a_if.count), 32'd1);

        tick(); tick(); tick();
        chk("a_pending", 32'(qa.size()), 32'd0);
        chk("b_pending", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_stream_unit.md
# ram_stream_unit

Parametrised data memory for the model CPU. It replaces the fixed 8-bit × 32 RAM that the input-echo program (read 32 values, write them back in order) exercises. It generalises width and depth and adds three access modes: random-access, stream (FIFO) and stack. It sits between the CPU datapath (address/data bus, read/write strobes) and the I/O path, with status flags the control unit polls.

## Interface
Parameters:
- DATA_W, 8, data word width
- DEPTH, 32, number of words, ≥2, need not be a power of two
- ADDR_W, $clog2(DEPTH), address/pointer width (derived)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous clear of pointers/count/err; latches mode
- mode  in  2  00 random, 01 stream, 10 stack, 11 treated as random; sampled only when rst or clr is high
- addr  in  ADDR_W  word address (random mode only)
- wr_en  in  1  write/push strobe
- rd_en  in  1  read/pop strobe
- din  in  DATA_W  write data
- dout  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse, dout valid
- full  out  1  count == DEPTH (stream/stack)
- empty  out  1  count == 0 (stream/stack)
- count  out  ADDR_W+1  occupied words (stream/stack); 0 in random mode
- err  out  1  sticky overflow/underflow/out-of-range flag

## Operation
- Reset (rst=1): wptr=rptr=count=0, dout=0, rd_valid=0, err=0, mode_q=mode. Memory array is not cleared.
- clr=1 (rst=0): same as reset except dout holds. Strobes that cycle are ignored.
- Random mode: wr_en writes din to mem[addr]. rd_en yields mem[addr] next cycle. On a same-address read and write, the read returns the old data. If addr ≥ DEPTH, the write is dropped, the read returns 0 with rd_valid=1, and err is set.
- Stream mode (FIFO): a write stores at wptr and increments count. A read returns mem[rptr] and decrements count. Pointers wrap from DEPTH-1 to 0.
  - Write when full: dropped, err set.
  - Read when empty: no rd_valid, err set.
  - Simultaneous read and write when empty: write accepted, read rejected (err set).
  - Simultaneous read and write when full: both accepted, count unchanged.
- Stack mode: count is the stack pointer. A push stores at mem[count] and increments count. A pop returns mem[count-1] and decrements count.
  - Push when full: dropped, err set.
  - Pop when empty: rejected, err set.
  - Simultaneous push and pop with count>0: returns old top, overwrites top with din, count unchanged.
  - Simultaneous push and pop with count==0: acts as push only, err set.
- err clears only on rst or clr.

## Timing
- Write latency 0: data is in the array after the strobe edge.
- Read latency 1: rd_en at edge N gives dout/rd_valid after edge N; rd_valid deasserts after edge N+1 unless rd_en repeats.
- Back-to-back reads every cycle are supported; throughput is 1 access per cycle per direction.
- full, empty and count are registered and reflect all strobes up to the previous edge.
- rst has priority over clr, and clr over strobes.

## Configuration
- RAM_MONITOR_EN defined: extra outputs mon_wptr (ADDR_W), mon_rptr (ADDR_W), mon_last_wr (DATA_W, last accepted write data, reset 0). These drive the CPU's monitor-signal bus for waveform debug.
- Undefined: those ports and their registers do not exist. Functional behaviour is identical.

## Structure
- Shared package cpu_pkg holds the ram_mode_t enum (RAM_RANDOM, RAM_STREAM, RAM_STACK) and the default DATA_W/DEPTH constants.
- One sub-module, ram_core: a single-port-write, single-port-read synchronous array with read-before-write behaviour. ram_stream_unit holds the pointer/count/mode/error logic.

## Test plan
- Stream echo: clr with mode=01, write 1..32 on consecutive cycles (full=1, count=32 after last), then read 32 times → dout sequence 1..32, each one cycle after rd_en; empty=1 and err=0 at end.
- Stream wrap: write 20, read 20, write 20, read 20 → outputs match inputs, pointers wrap, err=0.
- Stack: push 5,6,7; pop, pop → dout 7 then 6, count=1. A simultaneous push 9 and pop → dout 5, top becomes 9.
- Boundaries: push 33 words at DEPTH=32 → 33rd dropped, err=1. Pop on empty → no rd_valid, err stays 1 until clr.
- Random mode at DEPTH=24: write 0xAA to addr 3, read addr 3 → 0xAA. Same-cycle read+write 0x55 to addr 3 → read 0xAA, next read 0x55. Access addr 30 → dout 0, err=1.
- Reset mid-stream after 10 writes → count=0, empty=1, dout=0, mode re-sampled; following reads are rejected.
